// File: rtl/surf_event_merge.sv
// Merges the seven per-SURF 8-bit streams into one event stream. Each event
// is a header byte, then every enabled SURF's frame in index order, then a
// trailer byte carrying the mask of SURFs skipped on timeout.
module surf_event_merge #(
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 sysclk_i,
    input  logic                 sysclk_rst_i,
    input  logic [6:0]           enable_i,
    input  logic [55:0]          s_tdata,
    input  logic [6:0]           s_tvalid,
    output logic [6:0]           s_tready,
    input  logic [6:0]           s_tlast,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [6:0]           missing_o,
    output logic [CNT_WIDTH-1:0] event_count_o,
    output logic                 busy_o
);

    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        SEEK,
        DATA,
        TRAILER
    } state_t;

    state_t               state_q, state_d;
    logic [6:0]           emask_q, emask_d;
    logic [6:0]           miss_q, miss_d;
    logic [6:0]           miss_out_q, miss_out_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic                 started_q, started_d;

    logic                 sel_valid;
    logic                 timeout_hit;

    assign sel_valid   = s_tvalid[idx_q];
    assign timeout_hit = (TIMEOUT != 0) && !started_q && (tcnt_q == TW'(TIMEOUT));

    assign missing_o     = miss_out_q;
    assign event_count_o = cnt_q;
    assign busy_o        = (state_q != IDLE);

    // State and datapath registers; reset abandons any event in flight.
    always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
        if (sysclk_rst_i) begin
            state_q    <= IDLE;
            emask_q    <= '0;
            miss_q     <= '0;
            miss_out_q <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            tcnt_q     <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            emask_q    <= emask_d;
            miss_q     <= miss_d;
            miss_out_q <= miss_out_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            tcnt_q     <= tcnt_d;
            started_q  <= started_d;
        end
    end

    // Next-state logic and stream muxing; DATA is a combinational pass-through.
    always_comb begin
        state_d    = state_q;
        emask_d    = emask_q;
        miss_d     = miss_q;
        miss_out_d = miss_out_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        tcnt_d     = tcnt_q;
        started_d  = started_q;
        m_tvalid   = 1'b0;
        m_tdata    = '0;
        m_tlast    = 1'b0;
        s_tready   = '0;

        case (state_q)
            IDLE: begin
                if ((s_tvalid & enable_i) != '0) begin
                    emask_d = enable_i;
                    miss_d  = '0;
                    state_d = HEADER;
                end
            end

            HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = {1'b1, emask_q};
                if (m_tready) begin
                    idx_d   = '0;
                    state_d = SEEK;
                end
            end

            SEEK: begin
                if (emask_q[idx_q]) begin
                    tcnt_d    = '0;
                    started_d = 1'b0;
                    state_d   = DATA;
                end else if (idx_q == 3'd6) begin
                    state_d = TRAILER;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end

            DATA: begin
                // A timeout takes priority and suppresses the handshake in
                // that cycle, so a byte arriving on the same edge is left for
                // the next event rather than half-consumed.
                if (timeout_hit) begin
                    miss_d[idx_q] = 1'b1;
                    if (idx_q == 3'd6) begin
                        state_d = TRAILER;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEEK;
                    end
                end else begin
                    m_tdata         = s_tdata[{idx_q, 3'b000} +: 8];
                    m_tvalid        = sel_valid;
                    s_tready[idx_q] = m_tready;
                    if (sel_valid && m_tready) begin
                        started_d = 1'b1;
                        if (s_tlast[idx_q]) begin
                            if (idx_q == 3'd6) begin
                                state_d = TRAILER;
                            end else begin
                                idx_d   = idx_q + 3'd1;
                                state_d = SEEK;
                            end
                        end
                    end else if (!started_q && !sel_valid) begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end

            TRAILER: begin
                m_tvalid = 1'b1;
                m_tdata  = {1'b0, miss_q};
                m_tlast  = 1'b1;
                if (m_tready) begin
                    miss_out_d = miss_q;
                    cnt_d      = cnt_q + 1'b1;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_surf_event_merge.sv
// Scoreboard bench for surf_event_merge: events are described as per-SURF
// frames, the expected merged stream is computed from the event rules and
// queued, and a monitor compares every accepted output byte.
module tb_surf_event_merge;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    enable;
    logic [55:0]   s_tdata;
    logic [6:0]    s_tvalid;
    logic [6:0]    s_tready;
    logic [6:0]    s_tlast;
    logic [7:0]    m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [6:0]    missing;
    logic [CW-1:0] evcnt;
    logic          busy;

    surf_event_merge #(.TIMEOUT(16), .CNT_WIDTH(CW)) dut (
        .sysclk_i      (clk),
        .sysclk_rst_i  (rst),
        .enable_i      (enable),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_tlast       (s_tlast),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast),
        .missing_o     (missing),
        .event_count_o (evcnt),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    logic [8:0]  sq[7][$];    // upstream byte queues {tlast, data}
    logic [8:0]  fr[7][$];    // frames for the next event
    logic [8:0]  exp_q[$];    // expected output {tlast, data}
    logic [14:0] ev_q[$];     // expected {missing, count} after each event
    int          checks = 0;
    int          failures = 0;
    int          ev_done = 0;
    int          rdy_mode = 0; // 0: always ready, no gaps; 1: random
    logic [6:0]  cur_en = '0;
    int unsigned model_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Upstream SURF drivers and downstream ready generator.
    initial begin
        logic [6:0] fire;
        int gap[7];
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        fire     = '0;
        for (int n = 0; n < 7; n++) gap[n] = 0;
        forever begin
            @(negedge clk);
            fire = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            if (rst) begin
                s_tvalid = '0;
                for (int n = 0; n < 7; n++) sq[n].delete();
            end else begin
                for (int n = 0; n < 7; n++) begin
                    if (fire[n] && sq[n].size() > 0) begin
                        sq[n].delete(0);
                        s_tvalid[n] = 1'b0;
                        gap[n] = 0;
                    end
                    if (!s_tvalid[n] && sq[n].size() > 0) begin
                        if (rdy_mode == 0 || gap[n] >= 2 || $urandom_range(0, 1) == 1) begin
                            s_tvalid[n] = 1'b1;
                            s_tdata[n*8 +: 8] = sq[n][0][7:0];
                            s_tlast[n] = sq[n][0][8];
                        end else begin
                            gap[n]++;
                        end
                    end
                end
            end
            m_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: output byte order, hold-under-backpressure, per-event status.
    initial begin
        logic       stall;
        logic       ev_pend;
        logic [7:0] pdata;
        logic [8:0] e;
        logic [14:0] ev;
        logic [6:0] viol;
        stall = 1'b0;
        ev_pend = 1'b0;
        pdata = '0;
        viol = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
                ev_pend = 1'b0;
                viol = '0;
            end else begin
                viol |= s_tready & ~cur_en;
                if (ev_pend) begin
                    if (ev_q.size() == 0) begin
                        chk("event_unexpected", 1, 0);
                    end else begin
                        ev = ev_q.pop_front();
                        chk("missing_o", 32'(missing), 32'(ev[14:8]));
                        chk("event_count_o", 32'(evcnt), 32'(ev[7:0]));
                        chk("busy_after_event", 32'(busy), 0);
                        chk("tready_disabled", 32'(viol), 0);
                    end
                    viol = '0;
                    ev_pend = 1'b0;
                    ev_done++;
                end
                if (stall) begin
                    chk("hold_valid", 32'(m_tvalid), 1);
                    chk("hold_data", 32'(m_tdata), 32'(pdata));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_byte", 32'({m_tlast, m_tdata}), 32'h1ff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_byte", 32'({m_tlast, m_tdata}), 32'(e));
                        if (e[8]) ev_pend = 1'b1;
                    end
                end
                stall = m_tvalid && !m_tready;
                pdata = m_tdata;
            end
        end
    end

    task automatic clear_fr();
        for (int n = 0; n < 7; n++) fr[n].delete();
    endtask

    task automatic make_frame(input int n, input int len);
        fr[n].delete();
        for (int k = 0; k < len; k++) fr[n].push_back({(k == len - 1), 8'($urandom)});
    endtask

    // Reference: header, enabled non-silent frames in index order, trailer.
    task automatic launch_event(input logic [6:0] em);
        logic [6:0] miss;
        miss = '0;
        exp_q.push_back({1'b0, 1'b1, em});
        for (int n = 0; n < 7; n++) begin
            if (em[n]) begin
                if (fr[n].size() == 0) miss[n] = 1'b1;
                foreach (fr[n][k]) exp_q.push_back({1'b0, fr[n][k][7:0]});
            end
        end
        exp_q.push_back({1'b1, 1'b0, miss});
        model_cnt = (model_cnt + 1) % (1 << CW);
        ev_q.push_back({miss, CW'(model_cnt)});
        cur_en = em;
        for (int n = 0; n < 7; n++)
            if (em[n]) foreach (fr[n][k]) sq[n].push_back(fr[n][k]);
        enable = em;
    endtask

    task automatic run_event(input logic [6:0] em);
        int start;
        start = ev_done;
        launch_event(em);
        for (int c = 0; c < 3000 && ev_done == start; c++) @(posedge clk);
        if (ev_done == start) begin
            checks++;
            failures++;
            $display("FAIL event_wait actual=stuck required=done em=%0h", em);
        end
        clear_fr();
    endtask

    initial begin
        logic [6:0] em;
        int lo;
        rst = 1'b1;
        enable = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_m_tdata", 32'(m_tdata), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_missing", 32'(missing), 0);
        chk("rst_count", 32'(evcnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_enable_busy", 32'(busy), 0);

        // All SURFs, 2-byte frames {n, 0x10+n}.
        rdy_mode = 0;
        clear_fr();
        for (int n = 0; n < 7; n++) begin
            fr[n].push_back({1'b0, 8'(n)});
            fr[n].push_back({1'b1, 8'(8'h10 + n)});
        end
        run_event(7'h7F);

        // Sparse mask with a 1-byte frame.
        fr[0].push_back({1'b1, 8'hAA});
        fr[2].push_back({1'b0, 8'hBB});
        fr[2].push_back({1'b1, 8'hCC});
        run_event(7'h05);

        // SURF1 silent: skipped on timeout.
        fr[0].push_back({1'b0, 8'h31});
        fr[0].push_back({1'b1, 8'h32});
        run_event(7'h03);

        // Random backpressure and upstream gaps.
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) begin
            for (int n = 0; n < 7; n++) make_frame(n, 3);
            run_event(7'h7F);
        end
        for (int i = 0; i < 8; i++) begin
            em = 7'($urandom_range(1, 127));
            lo = 0;
            while (!em[lo]) lo++;
            for (int n = 0; n < 7; n++)
                if (n == lo || $urandom_range(0, 5) != 0) make_frame(n, $urandom_range(1, 4));
            run_event(em);
        end

        // Reset in the middle of SURF3's frame.
        rdy_mode = 0;
        for (int n = 0; n < 7; n++) make_frame(n, 3);
        launch_event(7'h7F);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (s_tready[3]) break;
        end
        chk("reached_surf3", 32'(s_tready[3]), 1);
        rst = 1'b1;
        #1;
        chk("midrst_m_tvalid", 32'(m_tvalid), 0);
        chk("midrst_m_tdata", 32'(m_tdata), 0);
        chk("midrst_s_tready", 32'(s_tready), 0);
        chk("midrst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        chk("midrst_count", 32'(evcnt), 0);
        chk("midrst_missing", 32'(missing), 0);
        chk("midrst_m_tlast", 32'(m_tlast), 0);
        repeat (2) @(posedge clk);
        exp_q.delete();
        ev_q.delete();
        model_cnt = 0;
        clear_fr();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        make_frame(0, 2);
        make_frame(4, 1);
        run_event(7'h11);

        // Counter wrap.
        for (int i = 0; i < (1 << CW); i++) begin
            fr[0].push_back({1'b1, 8'(i)});
            run_event(7'h01);
        end
        chk("wrapped_count", 32'(evcnt), 1);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
